au_sequencer: RTL
=================

// Module: au_sequencer
// PURPOSE
//  Multi-cycle controller directly upstream/downstream of the 8-bit arithmetic unit (au).
//  Latches an opcode, loads operands A/B from the shared data bus, and drives au_en/ac/a/b
//  for one EXEC cycle. Captures the au result t and flag gf into an accumulator and flag register.
//  Gives the test panel / next stage a start/busy/done handshake.
// PARAMETERS
//  DW   8  datapath width; must be 8 to match the au
//  OPW  4  opcode width; must be 4 to match au ac
// PORTS
//  clk     in   1    system clock, rising edge
//  rst_n   in   1    asynchronous active-low reset
//  start   in   1    request; sampled in IDLE only
//  op      in   OPW  opcode, sampled with start
//  din     in   DW   operand bus
//  t_in    in   DW   au result t
//  gf_in   in   1    au flag gf
//  au_en   out  1    au enable
//  ac      out  OPW  au control code
//  a       out  DW   operand A register
//  b       out  DW   operand B register
//  acc     out  DW   accumulator (written result)
//  flag    out  1    flag register
//  busy    out  1    high in every state except IDLE
//  done    out  1    one-cycle completion pulse
//  err     out  1    high for the done cycle of a rejected opcode
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; a,b,acc,op_q=0; flag,au_en,done,err,busy=0; ac=4'b0000.
//  Opcodes: ADD 1000, SUB 1001 (au computes b-a), PASS 0100/0101/1101. All others are invalid.
//  FSM: IDLE -> LOAD_A -> [LOAD_B] -> EXEC -> WB -> DONE -> IDLE.
//  - IDLE: on start=1, op_q<=op.
//      Valid op -> LOAD_A. Invalid op -> DONE with err set; acc and flag untouched.
//  - LOAD_A: a<=din at exit edge. Next is LOAD_B for ADD/SUB, EXEC for PASS (b holds its value).
//  - LOAD_B: b<=din at exit edge.
//  - EXEC: au_en=1, ac=op_q (registered outputs, valid the whole cycle).
//  - WB: acc<=t_in.
//      SUB: flag<=gf_in (1 when b>=a).
//      ADD: flag<=0.
//      PASS: flag unchanged.
//  - DONE: done=1 (err=1 if invalid), then IDLE.
//  au_en=0 and ac=0 in all states except EXEC, so t is high-Z outside EXEC.
//  Latency from the start-sampling edge to the done cycle:
//    ADD/SUB: 5 cycles. PASS: 4 cycles. Invalid: 1 cycle.
//  start while busy is ignored (no queueing). start held high re-triggers from IDLE after DONE.
//  Arithmetic is done only in the au. acc is modulo 2^8 with no saturation.
//  Reset mid-operation aborts and restores reset values; no partial write to acc.
// CONFIGURATION
//  AU_CHAIN_EN defined: extra input chain (1b), sampled with start.
//    chain=1 and valid op: skip LOAD_A; a<=acc at the IDLE exit edge.
//    ADD/SUB continue at LOAD_B (latency 4). PASS goes to EXEC (latency 3).
//  AU_CHAIN_EN undefined: no chain port; A is always loaded from din.
// STRUCTURE
//  au_pkg: opcode localparams (OP_ADD, OP_SUB, OP_PASS0/1/2), state encoding (S_IDLE..S_DONE), DW/OPW.
//  Sub-module au_opdec: combinational op -> {valid, needs_b, is_sub, is_add}.
//  FSM and registers stay in au_sequencer.
// TESTING
//  1 ADD op=1000, din A=0x12 then B=0x34, au model returns a+b
//    -> au_en high exactly 1 cycle with ac=1000; acc=0x46, flag=0; done 5 cycles after start.
//  2 SUB A=0x05, B=0x09 -> acc=0x04, flag=1.
//    Then A=0x09, B=0x05 -> acc=0xFC, flag=0.
//  3 PASS op=0100, A=0x5A, flag preset 1 -> acc=0x5A, flag=1, b unchanged, done 4 cycles after start.
//  4 Invalid op=0000 -> done+err 1 cycle after start; acc, flag, au_en unchanged; err clears next cycle.
//  5 rst_n low during EXEC -> au_en=0, ac=0, busy=0 without waiting for a clock edge; acc stays 0.
//    start pulse during busy -> ignored.
//  6 (AU_CHAIN_EN) acc=0x46, chain=1, ADD, B=0x01 -> a=0x46, acc=0x47, done 4 cycles after start.

Source files
------------

// File: rtl/au_pkg.sv
// Shared constants and types for the au sequencer slice.
// Optional feature macro: AU_CHAIN_EN (chained A operand from acc).
package au_pkg;

  localparam int DW  = 8;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_ADD   = 4'b1000;
  localparam logic [OPW-1:0] OP_SUB   = 4'b1001;
  localparam logic [OPW-1:0] OP_PASS0 = 4'b0100;
  localparam logic [OPW-1:0] OP_PASS1 = 4'b0101;
  localparam logic [OPW-1:0] OP_PASS2 = 4'b1101;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef struct packed {
    logic valid;
    logic needs_b;
    logic is_sub;
    logic is_add;
  } opdec_t;

endpackage

// File: rtl/au_opdec.sv
// Opcode classifier for the au sequencer.
// Pure combinational; no state.
module au_opdec
  import au_pkg::*;
(
  input  logic [OPW-1:0] op,
  output opdec_t         dec
);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op == OP_ADD): begin
        dec.valid   = 1'b1;
        dec.needs_b = 1'b1;
        dec.is_add  = 1'b1;
      end
      (op == OP_SUB): begin
        dec.valid   = 1'b1;
        dec.needs_b = 1'b1;
        dec.is_sub  = 1'b1;
      end
      (op == OP_PASS0),
      (op == OP_PASS1),
      (op == OP_PASS2): begin
        dec.valid = 1'b1;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/au_sequencer.sv
// Multi-cycle controller around the 8-bit au: load A/B, exec, writeback.
// Optional feature macro: AU_CHAIN_EN adds a chain input (A from acc).
module au_sequencer
  import au_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] op,
`ifdef AU_CHAIN_EN
  input  logic           chain,
`endif
  input  logic [DW-1:0]  din,
  input  logic [DW-1:0]  t_in,
  input  logic           gf_in,
  output logic           au_en,
  output logic [OPW-1:0] ac,
  output logic [DW-1:0]  a,
  output logic [DW-1:0]  b,
  output logic [DW-1:0]  acc,
  output logic           flag,
  output logic           busy,
  output logic           done,
  output logic           err
);

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] dec_op;
  opdec_t         dec;
  logic           go;
  logic           use_chain;

  // In IDLE the incoming op is decoded so the first edge can branch.
  assign dec_op = (state == S_IDLE) ? op : op_q;
  assign go     = (state == S_IDLE) && start;

`ifdef AU_CHAIN_EN
  assign use_chain = chain && dec.valid;
`else
  assign use_chain = 1'b0;
`endif

  au_opdec u_opdec (
    .op  (dec_op),
    .dec (dec)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!dec.valid)
            state_nxt = S_DONE;
          else if (use_chain)
            state_nxt = dec.needs_b ? S_LOAD_B : S_EXEC;
          else
            state_nxt = S_LOAD_A;
        end
      end
      S_LOAD_A:
        state_nxt = dec.needs_b ? S_LOAD_B : S_EXEC;
      S_LOAD_B: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      flag  <= 1'b0;
      au_en <= 1'b0;
      ac    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go)
        op_q <= op;
      if (go && use_chain)
        a <= acc;
      if (state == S_LOAD_A)
        a <= din;
      if (state == S_LOAD_B)
        b <= din;
      if (state == S_WB) begin
        acc <= t_in;
        if (dec.is_sub)
          flag <= gf_in;
        else if (dec.is_add)
          flag <= 1'b0;
      end
      // Outputs are registered from the next state.
      au_en <= (state_nxt == S_EXEC);
      ac    <= (state_nxt == S_EXEC) ? dec_op : '0;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      err   <= go && !dec.valid;
    end
  end

endmodule
